// File: rtl/smc_ahb_apb_bridge_lite30_if.sv
// AHB slave / APB master signal bundle for the SMC register bridge.
// The slave modport is the bridge's view; master is the surrounding system.
interface smc_ahb_apb_bridge_lite30_if #(
  parameter int P_ADDR_W30 = 5
);
  logic                  hsel30;
  logic [1:0]            htrans30;
  logic                  hwrite30;
  logic [2:0]            hsize30;
  logic [31:0]           haddr30;
  logic [31:0]           hwdata30;
  logic                  hready_in30;
  logic                  hready30;
  logic [1:0]            hresp30;
  logic [31:0]           hrdata30;
  logic                  psel30;
  logic                  penable30;
  logic                  pwrite30;
  logic [P_ADDR_W30-1:0] paddr30;
  logic [31:0]           pwdata30;
  logic [31:0]           prdata30;

  modport slave (
    input  hsel30, htrans30, hwrite30, hsize30, haddr30, hwdata30, hready_in30, prdata30,
    output hready30, hresp30, hrdata30, psel30, penable30, pwrite30, paddr30, pwdata30
  );

  modport master (
    output hsel30, htrans30, hwrite30, hsize30, haddr30, hwdata30, hready_in30, prdata30,
    input  hready30, hresp30, hrdata30, psel30, penable30, pwrite30, paddr30, pwdata30
  );
endinterface

// File: rtl/smc_ahb_apb_bridge_lite30.sv
// Single-clock AHB-to-APB bridge for the SMC register block: one word transfer
// at a time, zero-wait APB, two-cycle ERROR response for illegal transfers.
module smc_ahb_apb_bridge_lite30 #(
  parameter int P_ADDR_W30 = 5
) (
  input  logic                          pclk30,
  input  logic                          preset30,
  smc_ahb_apb_bridge_lite30_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WLATCH = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_DONE   = 3'd4,
    S_ERR1   = 3'd5,
    S_ERR2   = 3'd6
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic                  accept_s;
  logic                  legal_s;
  logic [P_ADDR_W30-1:0] paddr_r;
  logic                  pwrite_r;
  logic [31:0]           pwdata_r;
  logic [31:0]           hrdata_r;
  logic                  psel_r;
  logic                  penable_r;
  logic                  hready_r;
  logic [1:0]            hresp_r;

  function automatic logic is_legal(input logic [2:0] size, input logic [1:0] addr_lo);
    return (size == 3'b010) && (addr_lo == 2'b00);
  endfunction

  // Acceptance qualifier and legality of the presented address phase
  always_comb begin
    legal_s  = is_legal(bus.hsize30, bus.haddr30[1:0]);
    accept_s = 1'b0;
    if ((state_r == S_IDLE) || (state_r == S_DONE)) begin
      accept_s = bus.hsel30 & bus.htrans30[1] & bus.hready_in30 & hready_r;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = S_IDLE;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (!accept_s)         state_next_s = S_IDLE;
        else if (!legal_s)     state_next_s = S_ERR1;
        else if (bus.hwrite30) state_next_s = S_WLATCH;
        else                   state_next_s = S_SETUP;
      end
      S_WLATCH: state_next_s = S_SETUP;
      S_SETUP:  state_next_s = S_ACCESS;
      S_ACCESS: state_next_s = S_DONE;
      S_ERR1:   state_next_s = S_ERR2;
      S_ERR2:   state_next_s = S_IDLE;
      default:  state_next_s = S_IDLE;
    endcase
  end

  // State, datapath and outputs; outputs are decoded from the next state so they are registered
  always_ff @(posedge pclk30) begin
    if (preset30) begin
      state_r   <= S_IDLE;
      paddr_r   <= '0;
      pwrite_r  <= 1'b0;
      pwdata_r  <= 32'h0000_0000;
      hrdata_r  <= 32'h0000_0000;
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
      hready_r  <= 1'b1;
      hresp_r   <= 2'b00;
    end else begin
      state_r   <= state_next_s;
      psel_r    <= (state_next_s == S_SETUP) || (state_next_s == S_ACCESS);
      penable_r <= (state_next_s == S_ACCESS);
      hready_r  <= (state_next_s == S_IDLE) || (state_next_s == S_DONE) || (state_next_s == S_ERR2);
      hresp_r   <= ((state_next_s == S_ERR1) || (state_next_s == S_ERR2)) ? 2'b01 : 2'b00;
      // Illegal transfers never touch the APB side, so only legal ones load address/direction
      if (accept_s && legal_s) begin
        paddr_r  <= bus.haddr30[P_ADDR_W30-1:0];
        pwrite_r <= bus.hwrite30;
      end else begin
        paddr_r  <= paddr_r;
        pwrite_r <= pwrite_r;
      end
      if (state_r == S_WLATCH) begin
        pwdata_r <= bus.hwdata30;
      end else begin
        pwdata_r <= pwdata_r;
      end
      if ((state_r == S_ACCESS) && !pwrite_r) begin
        hrdata_r <= bus.prdata30;
      end else begin
        hrdata_r <= hrdata_r;
      end
    end
  end

  assign bus.paddr30   = paddr_r;
  assign bus.pwrite30  = pwrite_r;
  assign bus.pwdata30  = pwdata_r;
  assign bus.psel30    = psel_r;
  assign bus.penable30 = penable_r;
  assign bus.hready30  = hready_r;
  assign bus.hresp30   = hresp_r;
  assign bus.hrdata30  = hrdata_r;

endmodule

// File: tb/tb_smc_ahb_apb_bridge_lite30.sv
// Directed bench for smc_ahb_apb_bridge_lite30: read, write, error, back-to-back,
// reset abort and idle/busy/hready_in handling with hand-computed expectations.
module tb_smc_ahb_apb_bridge_lite30;

  logic pclk30;
  logic preset30;
  int   n_chk;
  int   n_err;

  smc_ahb_apb_bridge_lite30_if #(.P_ADDR_W30(5)) bus ();

  smc_ahb_apb_bridge_lite30 #(.P_ADDR_W30(5)) dut (
    .pclk30   (pclk30),
    .preset30 (preset30),
    .bus      (bus)
  );

  initial pclk30 = 1'b0;
  always #5 pclk30 = ~pclk30;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk30);
    #1;
  endtask

  task automatic drive(input logic [1:0] trans, input logic wr, input logic [2:0] size,
                       input logic [31:0] addr);
    bus.hsel30   = 1'b1;
    bus.htrans30 = trans;
    bus.hwrite30 = wr;
    bus.hsize30  = size;
    bus.haddr30  = addr;
  endtask

  task automatic apb_idle(input string tag);
    check({tag, "_psel"}, {31'd0, bus.psel30}, 32'd0);
    check({tag, "_pen"},  {31'd0, bus.penable30}, 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    preset30        = 1'b1;
    bus.hsel30      = 1'b0;
    bus.htrans30    = 2'b00;
    bus.hwrite30    = 1'b0;
    bus.hsize30     = 3'b010;
    bus.haddr30     = 32'h0000_0000;
    bus.hwdata30    = 32'h0000_0000;
    bus.hready_in30 = 1'b1;
    bus.prdata30    = 32'h0000_0000;
    tick();
    tick();
    preset30 = 1'b0;

    // Reset state
    check("rst_hready", {31'd0, bus.hready30}, 32'd1);
    check("rst_hresp",  {30'd0, bus.hresp30}, 32'd0);
    check("rst_hrdata", bus.hrdata30, 32'h0000_0000);
    check("rst_paddr",  {27'd0, bus.paddr30}, 32'd0);
    check("rst_pwdata", bus.pwdata30, 32'h0000_0000);
    check("rst_pwrite", {31'd0, bus.pwrite30}, 32'd0);
    apb_idle("rst");

    // Read from 0x0
    drive(2'b10, 1'b0, 3'b010, 32'h0000_0000);
    bus.prdata30 = 32'hA5A5_0001;
    tick();
    drive(2'b00, 1'b0, 3'b010, 32'h0000_0000);
    check("rd_setup_psel", {31'd0, bus.psel30}, 32'd1);
    check("rd_setup_pen",  {31'd0, bus.penable30}, 32'd0);
    check("rd_setup_hrdy", {31'd0, bus.hready30}, 32'd0);
    tick();
    check("rd_acc_psel",   {31'd0, bus.psel30}, 32'd1);
    check("rd_acc_pen",    {31'd0, bus.penable30}, 32'd1);
    check("rd_acc_pwrite", {31'd0, bus.pwrite30}, 32'd0);
    check("rd_acc_hrdy",   {31'd0, bus.hready30}, 32'd0);
    tick();
    bus.prdata30 = 32'hDEAD_BEEF;
    check("rd_done_hrdy",  {31'd0, bus.hready30}, 32'd1);
    check("rd_done_hrdata", bus.hrdata30, 32'hA5A5_0001);
    check("rd_done_hresp", {30'd0, bus.hresp30}, 32'd0);
    apb_idle("rd_done");
    tick();

    // Write to 0x0, data one cycle after acceptance
    drive(2'b10, 1'b1, 3'b010, 32'h0000_0000);
    tick();
    drive(2'b00, 1'b0, 3'b010, 32'h0000_0000);
    bus.hwdata30 = 32'h1234_5678;
    check("wr_wl_hrdy", {31'd0, bus.hready30}, 32'd0);
    apb_idle("wr_wl");
    tick();
    bus.hwdata30 = 32'h0BAD_0BAD;
    check("wr_setup_psel",   {31'd0, bus.psel30}, 32'd1);
    check("wr_setup_pen",    {31'd0, bus.penable30}, 32'd0);
    check("wr_setup_pwdata", bus.pwdata30, 32'h1234_5678);
    tick();
    check("wr_acc_pen",    {31'd0, bus.penable30}, 32'd1);
    check("wr_acc_pwdata", bus.pwdata30, 32'h1234_5678);
    check("wr_acc_pwrite", {31'd0, bus.pwrite30}, 32'd1);
    check("wr_acc_hrdy",   {31'd0, bus.hready30}, 32'd0);
    tick();
    check("wr_done_hrdy",   {31'd0, bus.hready30}, 32'd1);
    check("wr_hrdata_held", bus.hrdata30, 32'hA5A5_0001);
    apb_idle("wr_done");
    tick();

    // Illegal byte transfer at 0x1, with a legal read held during ERR1 that must be ignored
    drive(2'b10, 1'b0, 3'b000, 32'h0000_0001);
    tick();
    drive(2'b10, 1'b0, 3'b010, 32'h0000_0008);
    check("err1_hresp", {30'd0, bus.hresp30}, 32'd1);
    check("err1_hrdy",  {31'd0, bus.hready30}, 32'd0);
    apb_idle("err1");
    tick();
    drive(2'b00, 1'b0, 3'b010, 32'h0000_0000);
    check("err2_hresp", {30'd0, bus.hresp30}, 32'd1);
    check("err2_hrdy",  {31'd0, bus.hready30}, 32'd1);
    apb_idle("err2");
    tick();
    check("err_end_hresp", {30'd0, bus.hresp30}, 32'd0);
    check("err_end_hrdy",  {31'd0, bus.hready30}, 32'd1);
    apb_idle("err_end");
    tick();
    apb_idle("err_ign");

    // Back-to-back: read 0x14 then write 0x1C presented in DONE
    drive(2'b10, 1'b0, 3'b010, 32'h0000_0014);
    bus.prdata30 = 32'h0BAD_F00D;
    tick();
    drive(2'b00, 1'b0, 3'b010, 32'h0000_0000);
    check("b2b_rd_paddr", {27'd0, bus.paddr30}, 32'h0000_0014);
    tick();
    tick();
    check("b2b_rd_hrdy",   {31'd0, bus.hready30}, 32'd1);
    check("b2b_rd_hrdata", bus.hrdata30, 32'h0BAD_F00D);
    drive(2'b10, 1'b1, 3'b010, 32'h0000_001C);
    tick();
    drive(2'b00, 1'b0, 3'b010, 32'h0000_0000);
    bus.hwdata30 = 32'hCAFE_0001;
    check("b2b_wl_hrdy", {31'd0, bus.hready30}, 32'd0);
    apb_idle("b2b_wl");
    tick();
    check("b2b_setup_psel",  {31'd0, bus.psel30}, 32'd1);
    check("b2b_setup_paddr", {27'd0, bus.paddr30}, 32'h0000_001C);
    check("b2b_setup_pwrite", {31'd0, bus.pwrite30}, 32'd1);
    tick();
    check("b2b_acc_pen",    {31'd0, bus.penable30}, 32'd1);
    check("b2b_acc_pwdata", bus.pwdata30, 32'hCAFE_0001);
    tick();
    check("b2b_done_hrdy", {31'd0, bus.hready30}, 32'd1);
    check("b2b_hrdata_held", bus.hrdata30, 32'h0BAD_F00D);
    tick();

    // BUSY, deselected and hready_in low: all zero-wait OKAY with no APB cycle
    drive(2'b01, 1'b0, 3'b010, 32'h0000_0004);
    tick();
    check("busy_hrdy",  {31'd0, bus.hready30}, 32'd1);
    check("busy_hresp", {30'd0, bus.hresp30}, 32'd0);
    apb_idle("busy");
    drive(2'b10, 1'b0, 3'b010, 32'h0000_0004);
    bus.hsel30 = 1'b0;
    tick();
    check("nosel_hrdy", {31'd0, bus.hready30}, 32'd1);
    apb_idle("nosel");
    bus.hsel30      = 1'b1;
    bus.hready_in30 = 1'b0;
    tick();
    bus.hready_in30 = 1'b1;
    drive(2'b00, 1'b0, 3'b010, 32'h0000_0000);
    check("hrin_hrdy", {31'd0, bus.hready30}, 32'd1);
    apb_idle("hrin");
    tick();
    apb_idle("hrin2");

    // Reset asserted during ACCESS aborts the read
    drive(2'b10, 1'b0, 3'b010, 32'h0000_0000);
    bus.prdata30 = 32'h7777_7777;
    tick();
    drive(2'b00, 1'b0, 3'b010, 32'h0000_0000);
    tick();
    check("rstm_acc_pen", {31'd0, bus.penable30}, 32'd1);
    preset30 = 1'b1;
    tick();
    preset30 = 1'b0;
    check("rstm_hrdy",   {31'd0, bus.hready30}, 32'd1);
    check("rstm_hrdata", bus.hrdata30, 32'h0000_0000);
    check("rstm_hresp",  {30'd0, bus.hresp30}, 32'd0);
    apb_idle("rstm");
    tick();
    check("rstm_idle_hrdy",   {31'd0, bus.hready30}, 32'd1);
    check("rstm_idle_hrdata", bus.hrdata30, 32'h0000_0000);
    apb_idle("rstm_idle");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
